// File: rtl/trg_mon_data.sv
// Registered read-back mux for trigger-board monitor/config registers.
// Optional MON_CNT_SNAPSHOT_EN: shadow high words of the 32-bit hit counters on low-word read.
module trg_mon_data #(
   parameter logic [15:0] UNMAPPED_VAL = 16'h0000
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rd_in,
   input  logic [7:0]  rd_addr_in,
   input  logic [15:0] ctrl_reg_in,
   input  logic [15:0] cmd_reg_in,
   input  logic [15:0] trig_mode_mip1_in,
   input  logic [15:0] trg_mode_mip2_in,
   input  logic [15:0] trg_mode_gm1_in,
   input  logic [15:0] trg_mode_gm2_in,
   input  logic [15:0] trg_mode_ubs_in,
   input  logic [15:0] trg_mode_brst_in,
   input  logic [15:0] eff_trg_cnt_in,
   input  logic [15:0] coincid_trg_cnt_in,
   input  logic [15:0] hit_monit_fix_sel_in,
   input  logic [15:0] hit_monit_sel_in,
   input  logic [15:0] hit_monit_err_cnt_in,
   input  logic [15:0] hit_start_cnt_in,
   input  logic [31:0] hit_monit_cnt_0_in,
   input  logic [31:0] hit_monit_cnt_1_in,
   input  logic [15:0] busy_monit_fix_sel_in,
   input  logic [15:0] busy_monit_err_cnt_in,
   input  logic [15:0] busy_monit_cnt_in,
   input  logic [15:0] coincid_MIP1_cnt_in,
   input  logic [15:0] coincid_MIP2_cnt_in,
   input  logic [15:0] coincid_GM1_cnt_in,
   input  logic [15:0] coincid_GM2_cnt_in,
   input  logic [15:0] coincid_UBS_cnt_in,
   input  logic [15:0] logic_match_cnt_in,
   input  logic [15:0] ext_trg_cnt_in,
   input  logic [15:0] hit_ab_sel_in,
   input  logic [15:0] busy_ab_sel_in,
   input  logic [15:0] hit_mask_in,
   input  logic [15:0] busy_mask_in,
   input  logic [15:0] trg_match_win_in,
   input  logic [15:0] trg_dead_time_in,
   input  logic [15:0] config_received_in,
   input  logic [15:0] ext_trg_delay_in,
   input  logic [15:0] cycle_trg_period_in,
   output logic [15:0] mon_data_out
);

   localparam int unsigned DW = 16;

   logic [DW-1:0] rd_word_c;
   logic [DW-1:0] hit_hi_0_c;
   logic [DW-1:0] hit_hi_1_c;

`ifdef MON_CNT_SNAPSHOT_EN
   logic [DW-1:0] hit_hi_0_q;
   logic [DW-1:0] hit_hi_1_q;

   // Capture high words when the matching low word is read, for coherent 32-bit reads
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         hit_hi_0_q <= '0;
         hit_hi_1_q <= '0;
      end else if (rd_in) begin
         if (rd_addr_in == 8'd14) hit_hi_0_q <= hit_monit_cnt_0_in[31:16];
         if (rd_addr_in == 8'd16) hit_hi_1_q <= hit_monit_cnt_1_in[31:16];
      end
   end

   assign hit_hi_0_c = hit_hi_0_q;
   assign hit_hi_1_c = hit_hi_1_q;
`else
   assign hit_hi_0_c = hit_monit_cnt_0_in[31:16];
   assign hit_hi_1_c = hit_monit_cnt_1_in[31:16];
`endif

   // Address decode
   always_comb begin
      rd_word_c = UNMAPPED_VAL;
      case (rd_addr_in)
         8'd0:    rd_word_c = ctrl_reg_in;
         8'd1:    rd_word_c = cmd_reg_in;
         8'd2:    rd_word_c = trig_mode_mip1_in;
         8'd3:    rd_word_c = trg_mode_mip2_in;
         8'd4:    rd_word_c = trg_mode_gm1_in;
         8'd5:    rd_word_c = trg_mode_gm2_in;
         8'd6:    rd_word_c = trg_mode_ubs_in;
         8'd7:    rd_word_c = trg_mode_brst_in;
         8'd8:    rd_word_c = eff_trg_cnt_in;
         8'd9:    rd_word_c = coincid_trg_cnt_in;
         8'd10:   rd_word_c = hit_monit_fix_sel_in;
         8'd11:   rd_word_c = hit_monit_sel_in;
         8'd12:   rd_word_c = hit_monit_err_cnt_in;
         8'd13:   rd_word_c = hit_start_cnt_in;
         8'd14:   rd_word_c = hit_monit_cnt_0_in[15:0];
         8'd15:   rd_word_c = hit_hi_0_c;
         8'd16:   rd_word_c = hit_monit_cnt_1_in[15:0];
         8'd17:   rd_word_c = hit_hi_1_c;
         8'd18:   rd_word_c = busy_monit_fix_sel_in;
         8'd19:   rd_word_c = busy_monit_err_cnt_in;
         8'd20:   rd_word_c = busy_monit_cnt_in;
         8'd21:   rd_word_c = coincid_MIP1_cnt_in;
         8'd22:   rd_word_c = coincid_MIP2_cnt_in;
         8'd23:   rd_word_c = coincid_GM1_cnt_in;
         8'd24:   rd_word_c = coincid_GM2_cnt_in;
         8'd25:   rd_word_c = coincid_UBS_cnt_in;
         8'd26:   rd_word_c = logic_match_cnt_in;
         8'd27:   rd_word_c = ext_trg_cnt_in;
         8'd28:   rd_word_c = hit_ab_sel_in;
         8'd29:   rd_word_c = busy_ab_sel_in;
         8'd30:   rd_word_c = hit_mask_in;
         8'd31:   rd_word_c = busy_mask_in;
         8'd32:   rd_word_c = trg_match_win_in;
         8'd33:   rd_word_c = trg_dead_time_in;
         8'd34:   rd_word_c = config_received_in;
         8'd35:   rd_word_c = ext_trg_delay_in;
         8'd36:   rd_word_c = cycle_trg_period_in;
         default: rd_word_c = UNMAPPED_VAL;
      endcase
   end

   // Output register: holds while rd_in is low
   always_ff @(posedge clk_in) begin
      if (rst_in)     mon_data_out <= '0;
      else if (rd_in) mon_data_out <= rd_word_c;
   end

endmodule

// File: tb/tb_trg_mon_data.sv
// Bench for trg_mon_data: register-file model checked every cycle plus literal spot checks.
module tb_trg_mon_data;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic        rd_in = 1'b1;
   logic [7:0]  rd_addr_in = 8'd0;
   logic [15:0] mon_data_out;
   logic [15:0] words [0:36];

   int n_checks = 0;
   int n_fail = 0;

   always #5 clk_in = ~clk_in;

   trg_mon_data #(.UNMAPPED_VAL(16'h0000)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rd_in(rd_in), .rd_addr_in(rd_addr_in),
      .ctrl_reg_in(words[0]), .cmd_reg_in(words[1]),
      .trig_mode_mip1_in(words[2]), .trg_mode_mip2_in(words[3]),
      .trg_mode_gm1_in(words[4]), .trg_mode_gm2_in(words[5]),
      .trg_mode_ubs_in(words[6]), .trg_mode_brst_in(words[7]),
      .eff_trg_cnt_in(words[8]), .coincid_trg_cnt_in(words[9]),
      .hit_monit_fix_sel_in(words[10]), .hit_monit_sel_in(words[11]),
      .hit_monit_err_cnt_in(words[12]), .hit_start_cnt_in(words[13]),
      .hit_monit_cnt_0_in({words[15], words[14]}),
      .hit_monit_cnt_1_in({words[17], words[16]}),
      .busy_monit_fix_sel_in(words[18]), .busy_monit_err_cnt_in(words[19]),
      .busy_monit_cnt_in(words[20]), .coincid_MIP1_cnt_in(words[21]),
      .coincid_MIP2_cnt_in(words[22]), .coincid_GM1_cnt_in(words[23]),
      .coincid_GM2_cnt_in(words[24]), .coincid_UBS_cnt_in(words[25]),
      .logic_match_cnt_in(words[26]), .ext_trg_cnt_in(words[27]),
      .hit_ab_sel_in(words[28]), .busy_ab_sel_in(words[29]),
      .hit_mask_in(words[30]), .busy_mask_in(words[31]),
      .trg_match_win_in(words[32]), .trg_dead_time_in(words[33]),
      .config_received_in(words[34]), .ext_trg_delay_in(words[35]),
      .cycle_trg_period_in(words[36]),
      .mon_data_out(mon_data_out)
   );

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: register map as an array, shadows of high counter words
   logic [15:0] exp_q = 16'h0000;
   logic [15:0] sh0 = 16'h0000;
   logic [15:0] sh1 = 16'h0000;
   logic        model_valid = 1'b0;

   function automatic logic [15:0] model_word(input logic [7:0] a);
      if (a > 8'd36) return 16'h0000;
`ifdef MON_CNT_SNAPSHOT_EN
      if (a == 8'd15) return sh0;
      if (a == 8'd17) return sh1;
`endif
      return words[a];
   endfunction

   always @(posedge clk_in) begin
      if (rst_in) begin
         exp_q <= 16'h0000;
         sh0 <= 16'h0000;
         sh1 <= 16'h0000;
         model_valid <= 1'b1;
      end else if (rd_in) begin
         exp_q <= model_word(rd_addr_in);
         if (rd_addr_in == 8'd14) sh0 <= words[15];
         if (rd_addr_in == 8'd16) sh1 <= words[17];
      end
   end

   always @(negedge clk_in) begin
      if (model_valid) chk("model", mon_data_out, exp_q);
   end

   initial begin
      for (int i = 0; i < 37; i++) words[i] = (i % 2 == 0) ? 16'h3553 : 16'h0003;

      // Reset held with a read pending
      repeat (3) @(negedge clk_in);
      chk("reset", mon_data_out, 16'h0000);
      rst_in = 1'b0;
      @(negedge clk_in);
      chk("post_reset_addr0", mon_data_out, 16'h3553);

      // Full sweep of mapped addresses
      for (int a = 0; a < 37; a++) begin
         rd_addr_in = 8'(a);
         @(negedge clk_in);
         if (a == 1) chk("sweep_addr1", mon_data_out, 16'h0003);
         if (a == 36) chk("sweep_addr36", mon_data_out, 16'h3553);
      end

      // 32-bit hit counters split into two words
      words[14] = 16'h3553; words[15] = 16'h8435;
      words[16] = 16'h3553; words[17] = 16'h09a2;
      rd_addr_in = 8'd14; @(negedge clk_in); chk("hit0_lo", mon_data_out, 16'h3553);
      rd_addr_in = 8'd15; @(negedge clk_in); chk("hit0_hi", mon_data_out, 16'h8435);
      rd_addr_in = 8'd16; @(negedge clk_in); chk("hit1_lo", mon_data_out, 16'h3553);
      rd_addr_in = 8'd17; @(negedge clk_in); chk("hit1_hi", mon_data_out, 16'h09a2);

      // Unmapped range boundaries
      rd_addr_in = 8'd37;  @(negedge clk_in); chk("unmapped37", mon_data_out, 16'h0000);
      rd_addr_in = 8'd1;   @(negedge clk_in); chk("addr1", mon_data_out, 16'h0003);
      rd_addr_in = 8'd255; @(negedge clk_in); chk("unmapped255", mon_data_out, 16'h0000);

      // Hold while rd_in low
      rd_addr_in = 8'd1; @(negedge clk_in); chk("pre_hold", mon_data_out, 16'h0003);
      rd_in = 1'b0;
      rd_addr_in = 8'd2;
      words[1] = 16'hffff; words[2] = 16'habcd;
      repeat (3) begin
         @(negedge clk_in);
         chk("hold", mon_data_out, 16'h0003);
      end
      rd_in = 1'b1;
      @(negedge clk_in); chk("resume_addr2", mon_data_out, 16'habcd);

      // Low-then-high read with counter changing in between
      rd_addr_in = 8'd14; @(negedge clk_in); chk("snap_lo", mon_data_out, 16'h3553);
      words[14] = 16'h5678; words[15] = 16'h1234;
      rd_addr_in = 8'd15; @(negedge clk_in);
`ifdef MON_CNT_SNAPSHOT_EN
      chk("snap_hi", mon_data_out, 16'h8435);
`else
      chk("snap_hi", mon_data_out, 16'h1234);
`endif

      // Reset mid-read clears output (and shadows)
      rst_in = 1'b1; @(negedge clk_in); chk("mid_reset", mon_data_out, 16'h0000);
      rst_in = 1'b0; @(negedge clk_in);
`ifdef MON_CNT_SNAPSHOT_EN
      chk("post_reset_hi", mon_data_out, 16'h0000);
`else
      chk("post_reset_hi", mon_data_out, 16'h1234);
`endif
      rd_addr_in = 8'd0; @(negedge clk_in); chk("post_reset_addr0b", mon_data_out, 16'h3553);

      @(negedge clk_in);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/trg_mon_data.md
Name:
trg_mon_data

Overview:
- Read-back multiplexer for trigger-board monitor and configuration registers.
- Presents one selected 16-bit word on mon_data_out, registered, on request from the housekeeping/telemetry readout logic.
- Sits between the trigger-logic counters/config registers and the monitor-data serializer.
- The two 32-bit hit monitor counters are exposed as two 16-bit words each.

Parameters:
- UNMAPPED_VAL, 16'h0000, value returned for unmapped addresses.

Ports:
- clk_in  in  1  system clock; all logic on rising edge.
- rst_in  in  1  synchronous reset, active-high.
- rd_in  in  1  read enable; level-sensitive, sampled each cycle.
- rd_addr_in  in  8  word address of register to read.
- ctrl_reg_in  in  16  addr 0
- cmd_reg_in  in  16  addr 1
- trig_mode_mip1_in  in  16  addr 2
- trg_mode_mip2_in  in  16  addr 3
- trg_mode_gm1_in  in  16  addr 4
- trg_mode_gm2_in  in  16  addr 5
- trg_mode_ubs_in  in  16  addr 6
- trg_mode_brst_in  in  16  addr 7
- eff_trg_cnt_in  in  16  addr 8
- coincid_trg_cnt_in  in  16  addr 9
- hit_monit_fix_sel_in  in  16  addr 10
- hit_monit_sel_in  in  16  addr 11
- hit_monit_err_cnt_in  in  16  addr 12
- hit_start_cnt_in  in  16  addr 13
- hit_monit_cnt_0_in  in  32  addr 14 = [15:0], addr 15 = [31:16]
- hit_monit_cnt_1_in  in  32  addr 16 = [15:0], addr 17 = [31:16]
- busy_monit_fix_sel_in  in  16  addr 18
- busy_monit_err_cnt_in  in  16  addr 19
- busy_monit_cnt_in  in  16  addr 20
- coincid_MIP1_cnt_in  in  16  addr 21
- coincid_MIP2_cnt_in  in  16  addr 22
- coincid_GM1_cnt_in  in  16  addr 23
- coincid_GM2_cnt_in  in  16  addr 24
- coincid_UBS_cnt_in  in  16  addr 25
- logic_match_cnt_in  in  16  addr 26
- ext_trg_cnt_in  in  16  addr 27
- hit_ab_sel_in  in  16  addr 28
- busy_ab_sel_in  in  16  addr 29
- hit_mask_in  in  16  addr 30
- busy_mask_in  in  16  addr 31
- trg_match_win_in  in  16  addr 32
- trg_dead_time_in  in  16  addr 33
- config_received_in  in  16  addr 34
- ext_trg_delay_in  in  16  addr 35
- cycle_trg_period_in  in  16  addr 36
- mon_data_out  out  16  registered read data.

Behaviour:
- Reset: rst_in=1 at a rising edge sets mon_data_out to 16'h0000. Reset has priority over rd_in and clears the shadow registers (if present).
- Read: on each rising edge with rst_in=0 and rd_in=1, mon_data_out <= word mapped at rd_addr_in per the port list.
- Latency: exactly 1 cycle from address/rd_in sampling to output.
- Continuous read: while rd_in stays high, the output tracks live input values and address changes every cycle; no handshake and no acknowledge.
- rd_in=0: mon_data_out holds its last value.
- Addresses 37..255: output UNMAPPED_VAL.
- Inputs are treated as synchronous to clk_in; no CDC inside the block.
- Reset mid-read: the output goes to 0 on that edge, and reads resume on the first non-reset edge with rd_in=1.

Optional Feature:
- Macro: MON_CNT_SNAPSHOT_EN.
- Defined:
  - A read of addr 14 also captures hit_monit_cnt_0_in[31:16] into a 16-bit shadow; a read of addr 16 captures hit_monit_cnt_1_in[31:16] into a separate shadow.
  - Addr 15 and addr 17 return their shadow instead of the live high word, giving a coherent 32-bit value when low is read before high.
  - Shadows reset to 0 and update only on the low-word read edge.
- Not defined: addr 15 and addr 17 return the live high word; no shadow registers exist.

Test Plan:
1. Hold rst_in=1 with rd_in=1 and addr 0 -> mon_data_out=16'h0000. Release reset -> 16'h3553 (ctrl_reg_in=16'h3553) one cycle later.
2. rd_in=1, sweep addr 0..36 with the alternating 16'h3553/16'h0003 stimulus -> each output equals the mapped input one cycle after its address. Example: addr 1 -> 16'h0003.
3. hit_monit_cnt_0_in=32'h84353553, hit_monit_cnt_1_in=32'h09a23553; read addr 14,15,16,17 -> 3553, 8435, 3553, 09a2.
4. Addr 37 and addr 255 -> 16'h0000.
5. Read addr 1 (gets 0003), drop rd_in, change addr and inputs -> output stays 16'h0003.
6. With MON_CNT_SNAPSHOT_EN: read addr 14, change hit_monit_cnt_0_in to 32'h12345678, read addr 15 -> 16'h8435. Without the macro -> 16'h1234.
